up_controller_seq: RTL and testbench
====================================

// Module: up_controller_seq
// PURPOSE
//  Parametrised microprogram sequencer for the small datapath CPU; drives ALU op, IR/PC/SP/regbank
//  write strobes and memory ALE/WE. Adds what the fixed controller lacked: configurable boot-load
//  count, memory wait states (mem_rdy), Z-conditional branch, push/pop, interrupt entry, HALT.
//  Sits between instruction register/flags and datapath; one instance per core.
// PARAMETERS
//  IR_W       4   opcode width; opcodes >= 16 decode as NOP
//  OP_W       5   ALU/datapath op width (>= 5)
//  RBS_W      3   regbank select width; default select = 3'b100 (zero-extended)
//  BOOT_REGS  3   registers loaded from memory after reset (1..2**RBS_W-1)
//  WAIT_EN    1   1: honour mem_rdy; 0: mem_rdy ignored (treated as 1)
//  INT_EN     1   1: interrupt entry enabled; 0: irq ignored except HALT wake
// PORTS
//  clk      in   1      clock, rising edge
//  rst      in   1      synchronous reset, active high
//  irq      in   1      level interrupt request
//  ir       in   IR_W   current opcode
//  z        in   1      ALU zero flag
//  mem_rdy  in   1      memory read data / write complete this cycle
//  op       out  OP_W   datapath op
//  ir_we, pc_we, rb_we, sp_we, mem_we, ale  out 1  strobes
//  rb_sel   out  RBS_W  regbank select
//  int_ack  out  1      one-cycle pulse in INT_VEC
//  halted   out  1      high while in HALT
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high. Outputs combinational from state
//   (Moore) except strobe gating by mem_rdy. Defaults every state: op=0, rb_sel=4, all strobes 0.
//  Reset: state<=BOOT_ADDR, step<=0, ie<=1; reset mid-instruction abandons it, no strobe that cycle.
//  States/transitions:
//   BOOT_ADDR  op=10000 ale=1 -> BOOT_LOAD(k=1)
//   BOOT_LOAD  op=10000+k, rb_sel=k-1, rb_we=mem_rdy, ale=(k<BOOT_REGS);
//              mem_rdy=0 holds k; k==BOOT_REGS & mem_rdy -> FETCH else k++
//   FETCH      op=10100 ale=1 -> DECODE
//   DECODE     op=10101, ir_we=pc_we=mem_rdy; mem_rdy=0 holds -> EXEC(step=0)
//   EXEC by ir (op={0,ir} zero-extended unless stated):
//    0-3  rb_we=1; 1 cycle
//    4-6  3 cycles; rb_sel per step: ir4 {4,5,4}, ir5 {5,6,5}, ir6 {6,7,6}; rb_we=1 each
//    7    BZ: pc_we=z; 1 cycle
//    8    PUSH: mem_we=1 sp_we=mem_rdy; holds until mem_rdy
//    9    POP: op=00111 sp_we=1 step0; ale=1 step1; rb_we=mem_rdy step2, holds until mem_rdy
//    A    CLI ie<=0 / B STI ie<=1; 1 cycle
//    F    HALT -> HALT
//    other NOP, 1 cycle
//   Instruction end: irq & ie & INT_EN -> INT_PUSH else FETCH
//   INT_PUSH   op=11000 mem_we=1, sp_we=mem_rdy; holds until mem_rdy -> INT_VEC
//   INT_VEC    op=11001 pc_we=1 int_ack=1, ie<=0 -> FETCH
//   HALT       halted=1; irq -> (ie&INT_EN ? INT_PUSH : FETCH)
//  Boundaries: irq ignored during boot/FETCH/DECODE (sampled only at instruction end); STI
//   with irq high enters INT_PUSH immediately after. WAIT_EN=0: every hold is single-cycle.
//   BOOT_REGS=1: BOOT_LOAD single step, ale=0. Step counter 2 bits, wraps never (max step 2).
//   Undefined state encodings -> BOOT_ADDR.
// STRUCTURE
//  Package up_ctrl_pkg: state enum, op constants (OP_BOOT=10000, OP_FETCH=10100,
//   OP_DECODE=10101, OP_SPDEC=00111, OP_INTPUSH=11000, OP_INTVEC=11001), opcode names.
//  Sub-module up_ctrl_decode: combinational ir -> {class, n_steps}; sequencer stays in top.
// TESTING
//  1 Reset, mem_rdy=1: BOOT_ADDR, 3 BOOT_LOAD cycles rb_sel 0,1,2 rb_we=1, FETCH at cycle 4.
//  2 mem_rdy=0 for 3 cycles in DECODE: ir_we/pc_we low 3 cycles, single pulse when mem_rdy=1.
//  3 ir=5: 3 EXEC cycles rb_sel 5,6,5 op=00101, back to FETCH; ir=7 z=1 pc_we=1, z=0 pc_we=0.
//  4 irq=1 during ir=4 step1: stays pending; after step2 INT_PUSH, INT_VEC int_ack 1 cycle,
//    ie=0 so second irq ignored until STI (ir=B), then INT_PUSH next cycle.
//  5 ir=F: halted=1 indefinitely; irq with ie=0 -> FETCH, halted=0; rst mid-PUSH -> BOOT_ADDR,
//    mem_we=0 that cycle.
//  6 Params BOOT_REGS=1, WAIT_EN=0, IR_W=6: ir=6'h20 NOP 1 cycle, mem_rdy=0 never stalls.

Source files
------------

// File: rtl/up_controller_seq_pkg.sv
// Shared types and constants for the microprogram sequencer: state encoding,
// instruction classes, fixed datapath op codes and opcode names.
package up_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_BOOT_ADDR = 4'd0,
    ST_BOOT_LOAD = 4'd1,
    ST_FETCH     = 4'd2,
    ST_DECODE    = 4'd3,
    ST_EXEC      = 4'd4,
    ST_INT_PUSH  = 4'd5,
    ST_INT_VEC   = 4'd6,
    ST_HALT      = 4'd7
  } state_e;

  typedef enum logic [3:0] {
    CL_NOP  = 4'd0,
    CL_ALU1 = 4'd1,
    CL_ALU3 = 4'd2,
    CL_BZ   = 4'd3,
    CL_PUSH = 4'd4,
    CL_POP  = 4'd5,
    CL_CLI  = 4'd6,
    CL_STI  = 4'd7,
    CL_HALT = 4'd8
  } iclass_e;

  localparam logic [4:0] OP_BOOT    = 5'b10000;
  localparam logic [4:0] OP_FETCH   = 5'b10100;
  localparam logic [4:0] OP_DECODE  = 5'b10101;
  localparam logic [4:0] OP_SPDEC   = 5'b00111;
  localparam logic [4:0] OP_INTPUSH = 5'b11000;
  localparam logic [4:0] OP_INTVEC  = 5'b11001;

  localparam logic [3:0] OPC_BZ   = 4'h7;
  localparam logic [3:0] OPC_PUSH = 4'h8;
  localparam logic [3:0] OPC_POP  = 4'h9;
  localparam logic [3:0] OPC_CLI  = 4'hA;
  localparam logic [3:0] OPC_STI  = 4'hB;
  localparam logic [3:0] OPC_HALT = 4'hF;

  // Classes whose final step stalls until memory signals completion.
  function automatic logic needs_mem(iclass_e c);
    return (c == CL_PUSH) || (c == CL_POP);
  endfunction

endpackage

// File: rtl/up_controller_seq_if.sv
// Controller <-> datapath bundle: flags/opcode/memory-ready in, ops and strobes out.
interface up_controller_seq_if #(
  parameter int IR_W  = 4,
  parameter int OP_W  = 5,
  parameter int RBS_W = 3
) ();
  logic             irq;
  logic [IR_W-1:0]  ir;
  logic             z;
  logic             mem_rdy;
  logic [OP_W-1:0]  op;
  logic             ir_we;
  logic             pc_we;
  logic             rb_we;
  logic             sp_we;
  logic             mem_we;
  logic             ale;
  logic [RBS_W-1:0] rb_sel;
  logic             int_ack;
  logic             halted;

  modport master (
    input  irq, ir, z, mem_rdy,
    output op, ir_we, pc_we, rb_we, sp_we, mem_we, ale, rb_sel, int_ack, halted
  );

  modport slave (
    output irq, ir, z, mem_rdy,
    input  op, ir_we, pc_we, rb_we, sp_we, mem_we, ale, rb_sel, int_ack, halted
  );
endinterface

// File: rtl/up_controller_seq_decode.sv
// Opcode classifier: maps the instruction register to an execution class,
// the number of EXEC steps, and the 4-bit code used for the datapath op.
module up_ctrl_decode
  import up_ctrl_pkg::*;
#(
  parameter int IR_W = 4
) (
  input  logic [IR_W-1:0] ir,
  output iclass_e         iclass,
  output logic [1:0]      n_steps,
  output logic [3:0]      code
);

  logic [3:0] nib;
  logic       wide;

  assign nib  = ir[3:0];
  assign wide = (32'(ir) > 32'd15);

  always_comb begin
    iclass  = CL_NOP;
    n_steps = 2'd1;
    code    = nib;
    if (wide) begin
      // Opcodes beyond the 4-bit map are plain NOPs with a zero op.
      code = 4'h0;
    end else begin
      case (nib)
        4'h0, 4'h1, 4'h2, 4'h3: iclass = CL_ALU1;
        4'h4, 4'h5, 4'h6: begin
          iclass  = CL_ALU3;
          n_steps = 2'd3;
        end
        OPC_BZ:   iclass = CL_BZ;
        OPC_PUSH: iclass = CL_PUSH;
        OPC_POP: begin
          iclass  = CL_POP;
          n_steps = 2'd3;
        end
        OPC_CLI:  iclass = CL_CLI;
        OPC_STI:  iclass = CL_STI;
        OPC_HALT: iclass = CL_HALT;
        default:  iclass = CL_NOP;
      endcase
    end
  end

endmodule

// File: rtl/up_controller_seq.sv
// Microprogram sequencer: boot-load, fetch/decode/execute with memory wait
// states, Z branch, push/pop, interrupt entry and HALT.
module up_controller_seq
  import up_ctrl_pkg::*;
#(
  parameter int IR_W      = 4,
  parameter int OP_W      = 5,
  parameter int RBS_W     = 3,
  parameter int BOOT_REGS = 3,
  parameter int WAIT_EN   = 1,
  parameter int INT_EN    = 1
) (
  input logic                clk,
  input logic                rst,
  up_controller_seq_if.master bus
);

  localparam bit               WAIT_ON = (WAIT_EN != 0);
  localparam bit               INT_ON  = (INT_EN != 0);
  localparam logic [RBS_W-1:0] SEL_DEF = RBS_W'(4);
  localparam logic [RBS_W-1:0] K_LAST  = RBS_W'(BOOT_REGS);

  state_e           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [RBS_W-1:0] boot_k_q, boot_k_d;
  logic             ie_q, ie_d;

  iclass_e          iclass;
  logic [1:0]       n_steps;
  logic [3:0]       code;
  logic             rdy;
  logic             last_step;
  logic             int_go;

  logic [OP_W-1:0]  op_c;
  logic [RBS_W-1:0] sel_c;
  logic             ir_we_c, pc_we_c, rb_we_c, sp_we_c, mem_we_c, ale_c;
  logic             int_ack_c, halted_c;

  up_ctrl_decode #(.IR_W(IR_W)) u_decode (
    .ir      (bus.ir),
    .iclass  (iclass),
    .n_steps (n_steps),
    .code    (code)
  );

  assign rdy       = WAIT_ON ? bus.mem_rdy : 1'b1;
  assign last_step = (step_q == (n_steps - 2'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BOOT_ADDR;
      step_q   <= 2'd0;
      boot_k_q <= RBS_W'(1);
      ie_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      boot_k_q <= boot_k_d;
      ie_q     <= ie_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    boot_k_d  = boot_k_q;
    ie_d      = ie_q;
    int_go    = 1'b0;
    op_c      = '0;
    sel_c     = SEL_DEF;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    rb_we_c   = 1'b0;
    sp_we_c   = 1'b0;
    mem_we_c  = 1'b0;
    ale_c     = 1'b0;
    int_ack_c = 1'b0;
    halted_c  = 1'b0;

    case (state_q)
      ST_BOOT_ADDR: begin
        op_c     = OP_W'(OP_BOOT);
        ale_c    = 1'b1;
        boot_k_d = RBS_W'(1);
        state_d  = ST_BOOT_LOAD;
      end
      ST_BOOT_LOAD: begin
        op_c    = OP_W'(OP_BOOT) + OP_W'(boot_k_q);
        sel_c   = boot_k_q - RBS_W'(1);
        rb_we_c = rdy;
        ale_c   = (boot_k_q < K_LAST);
        if (rdy) begin
          if (boot_k_q == K_LAST) state_d = ST_FETCH;
          else                    boot_k_d = boot_k_q + RBS_W'(1);
        end
      end
      ST_FETCH: begin
        op_c    = OP_W'(OP_FETCH);
        ale_c   = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        op_c    = OP_W'(OP_DECODE);
        ir_we_c = rdy;
        pc_we_c = rdy;
        if (rdy) begin
          step_d  = 2'd0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        op_c = OP_W'(code);
        case (iclass)
          CL_ALU1: rb_we_c = 1'b1;
          CL_ALU3: begin
            rb_we_c = 1'b1;
            sel_c   = RBS_W'(code) + ((step_q == 2'd1) ? RBS_W'(1) : RBS_W'(0));
          end
          CL_BZ:   pc_we_c = bus.z;
          CL_PUSH: begin
            mem_we_c = 1'b1;
            sp_we_c  = rdy;
          end
          CL_POP: begin
            case (step_q)
              2'd0: begin
                op_c    = OP_W'(OP_SPDEC);
                sp_we_c = 1'b1;
              end
              2'd1:    ale_c   = 1'b1;
              default: rb_we_c = rdy;
            endcase
          end
          CL_CLI:  ie_d = 1'b0;
          CL_STI:  ie_d = 1'b1;
          default: ;
        endcase
        // Interrupt sampling uses the post-instruction ie so STI takes effect at once.
        int_go = bus.irq && ie_d && INT_ON;
        if (iclass == CL_HALT) begin
          state_d = ST_HALT;
        end else if (last_step) begin
          if (!needs_mem(iclass) || rdy) state_d = int_go ? ST_INT_PUSH : ST_FETCH;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      ST_INT_PUSH: begin
        op_c     = OP_W'(OP_INTPUSH);
        mem_we_c = 1'b1;
        sp_we_c  = rdy;
        if (rdy) state_d = ST_INT_VEC;
      end
      ST_INT_VEC: begin
        op_c      = OP_W'(OP_INTVEC);
        pc_we_c   = 1'b1;
        int_ack_c = 1'b1;
        ie_d      = 1'b0;
        state_d   = ST_FETCH;
      end
      ST_HALT: begin
        halted_c = 1'b1;
        if (bus.irq) state_d = (ie_q && INT_ON) ? ST_INT_PUSH : ST_FETCH;
      end
      default: state_d = ST_BOOT_ADDR;
    endcase

    // A reset cycle abandons whatever was in flight without issuing strobes.
    if (rst) begin
      op_c      = '0;
      sel_c     = SEL_DEF;
      ir_we_c   = 1'b0;
      pc_we_c   = 1'b0;
      rb_we_c   = 1'b0;
      sp_we_c   = 1'b0;
      mem_we_c  = 1'b0;
      ale_c     = 1'b0;
      int_ack_c = 1'b0;
      halted_c  = 1'b0;
    end
  end

  assign bus.op      = op_c;
  assign bus.rb_sel  = sel_c;
  assign bus.ir_we   = ir_we_c;
  assign bus.pc_we   = pc_we_c;
  assign bus.rb_we   = rb_we_c;
  assign bus.sp_we   = sp_we_c;
  assign bus.mem_we  = mem_we_c;
  assign bus.ale     = ale_c;
  assign bus.int_ack = int_ack_c;
  assign bus.halted  = halted_c;

endmodule

// File: tb/tb_up_controller_seq.sv
// Scoreboard bench for up_controller_seq: default-parameter core plus a
// BOOT_REGS=1 / WAIT_EN=0 / IR_W=6 core, directed per-cycle expectations.
module tb_up_controller_seq;

  localparam logic [7:0] IRW  = 8'h80;
  localparam logic [7:0] PCW  = 8'h40;
  localparam logic [7:0] RBW  = 8'h20;
  localparam logic [7:0] SPW  = 8'h10;
  localparam logic [7:0] MEMW = 8'h08;
  localparam logic [7:0] ALE  = 8'h04;
  localparam logic [7:0] ACK  = 8'h02;
  localparam logic [7:0] HLT  = 8'h01;

  typedef struct {
    logic [15:0] v;
    string       nm;
  } item_t;

  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  int   total = 0;
  int   bad = 0;
  item_t q1[$];
  item_t q2[$];

  always #5 clk = ~clk;

  up_controller_seq_if #(.IR_W(4), .OP_W(5), .RBS_W(3)) bus1 ();
  up_controller_seq_if #(.IR_W(6), .OP_W(5), .RBS_W(3)) bus2 ();

  up_controller_seq #(.IR_W(4), .OP_W(5), .RBS_W(3), .BOOT_REGS(3), .WAIT_EN(1), .INT_EN(1))
    dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  up_controller_seq #(.IR_W(6), .OP_W(5), .RBS_W(3), .BOOT_REGS(1), .WAIT_EN(0), .INT_EN(1))
    dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  function automatic logic [15:0] mk(logic [4:0] op, logic [2:0] sel, logic [7:0] s);
    return {op, sel, s};
  endfunction

  function automatic logic [15:0] act1();
    return {bus1.op, bus1.rb_sel, bus1.ir_we, bus1.pc_we, bus1.rb_we, bus1.sp_we,
            bus1.mem_we, bus1.ale, bus1.int_ack, bus1.halted};
  endfunction

  function automatic logic [15:0] act2();
    return {bus2.op, bus2.rb_sel, bus2.ir_we, bus2.pc_we, bus2.rb_we, bus2.sp_we,
            bus2.mem_we, bus2.ale, bus2.int_ack, bus2.halted};
  endfunction

  // Monitors: one expectation per cycle, compared on the falling edge.
  always @(negedge clk) begin
    if (q1.size() > 0) begin
      item_t it;
      logic [15:0] a;
      it = q1.pop_front();
      a  = act1();
      total++;
      if (a !== it.v) begin
        bad++;
        $display("FAIL core1 %s: got {op,sel,strb}=%h expected %h", it.nm, a, it.v);
      end
    end
  end

  always @(negedge clk) begin
    if (q2.size() > 0) begin
      item_t it;
      logic [15:0] a;
      it = q2.pop_front();
      a  = act2();
      total++;
      if (a !== it.v) begin
        bad++;
        $display("FAIL core2 %s: got {op,sel,strb}=%h expected %h", it.nm, a, it.v);
      end
    end
  end

  task automatic cyc1(input logic [15:0] v, input string nm);
    q1.push_back('{v, nm});
    @(posedge clk); #1;
  endtask

  task automatic cyc2(input logic [15:0] v, input string nm);
    q2.push_back('{v, nm});
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bus1.irq = 1'b0; bus1.ir = 4'h0; bus1.z = 1'b0; bus1.mem_rdy = 1'b1;
    bus2.irq = 1'b0; bus2.ir = 6'h00; bus2.z = 1'b0; bus2.mem_rdy = 1'b0;
    @(posedge clk); #1;

    // Reset and boot load with memory always ready
    cyc1(mk(5'h00, 3'd4, 8'h00), "reset0");
    cyc1(mk(5'h00, 3'd4, 8'h00), "reset1");
    rst1 = 1'b0;
    cyc1(mk(5'h10, 3'd4, ALE), "boot_addr");
    cyc1(mk(5'h11, 3'd0, RBW | ALE), "boot_k1");
    cyc1(mk(5'h12, 3'd1, RBW | ALE), "boot_k2");
    cyc1(mk(5'h13, 3'd2, RBW), "boot_k3");
    cyc1(mk(5'h14, 3'd4, ALE), "fetch_first");

    // DECODE stalled three cycles
    bus1.ir = 4'h5; bus1.mem_rdy = 1'b0;
    cyc1(mk(5'h15, 3'd4, 8'h00), "decode_wait0");
    cyc1(mk(5'h15, 3'd4, 8'h00), "decode_wait1");
    cyc1(mk(5'h15, 3'd4, 8'h00), "decode_wait2");
    bus1.mem_rdy = 1'b1;
    cyc1(mk(5'h15, 3'd4, IRW | PCW), "decode_go");

    // ir=5 three-step ALU
    cyc1(mk(5'h05, 3'd5, RBW), "alu5_s0");
    cyc1(mk(5'h05, 3'd6, RBW), "alu5_s1");
    cyc1(mk(5'h05, 3'd5, RBW), "alu5_s2");
    cyc1(mk(5'h14, 3'd4, ALE), "fetch_after_alu5");

    // BZ taken / not taken
    bus1.ir = 4'h7; bus1.z = 1'b1;
    cyc1(mk(5'h15, 3'd4, IRW | PCW), "decode_bz1");
    cyc1(mk(5'h07, 3'd4, PCW), "bz_taken");
    cyc1(mk(5'h14, 3'd4, ALE), "fetch_bz1");
    bus1.z = 1'b0;
    cyc1(mk(5'h15, 3'd4, IRW | PCW), "decode_bz0");
    cyc1(mk(5'h07, 3'd4, 8'h00), "bz_not_taken");
    cyc1(mk(5'h14, 3'd4, ALE), "fetch_bz0");

    // irq arriving mid ir=4 is held until instruction end
    bus1.ir = 4'h4;
    cyc1(mk(5'h15, 3'd4, IRW | PCW), "decode_alu4");
    cyc1(mk(5'h04, 3'd4, RBW), "alu4_s0");
    bus1.irq = 1'b1;
    cyc1(mk(5'h04, 3'd5, RBW), "alu4_s1_irq");
    cyc1(mk(5'h04, 3'd4, RBW), "alu4_s2_irq");
    cyc1(mk(5'h18, 3'd4, MEMW | SPW), "int_push");
    cyc1(mk(5'h19, 3'd4, PCW | ACK), "int_vec");
    bus1.ir = 4'h0;
    cyc1(mk(5'h14, 3'd4, ALE), "fetch_ie0");
    cyc1(mk(5'h15, 3'd4, IRW | PCW), "decode_ie0");
    cyc1(mk(5'h00, 3'd4, RBW), "alu0_irq_masked");
    cyc1(mk(5'h14, 3'd4, ALE), "fetch_masked");
    bus1.ir = 4'hB;
    cyc1(mk(5'h15, 3'd4, IRW | PCW), "decode_sti");
    cyc1(mk(5'h0B, 3'd4, 8'h00), "sti");
    cyc1(mk(5'h18, 3'd4, MEMW | SPW), "int_push_after_sti");
    bus1.irq = 1'b0;
    cyc1(mk(5'h19, 3'd4, PCW | ACK), "int_vec2");
    cyc1(mk(5'h14, 3'd4, ALE), "fetch_after_int2");

    // PUSH with memory wait
    bus1.ir = 4'h8;
    cyc1(mk(5'h15, 3'd4, IRW | PCW), "decode_push");
    bus1.mem_rdy = 1'b0;
    cyc1(mk(5'h08, 3'd4, MEMW), "push_wait0");
    cyc1(mk(5'h08, 3'd4, MEMW), "push_wait1");
    bus1.mem_rdy = 1'b1;
    cyc1(mk(5'h08, 3'd4, MEMW | SPW), "push_done");
    cyc1(mk(5'h14, 3'd4, ALE), "fetch_after_push");

    // POP with memory wait on the final step
    bus1.ir = 4'h9;
    cyc1(mk(5'h15, 3'd4, IRW | PCW), "decode_pop");
    cyc1(mk(5'h07, 3'd4, SPW), "pop_s0");
    cyc1(mk(5'h09, 3'd4, ALE), "pop_s1");
    bus1.mem_rdy = 1'b0;
    cyc1(mk(5'h09, 3'd4, 8'h00), "pop_s2_wait");
    bus1.mem_rdy = 1'b1;
    cyc1(mk(5'h09, 3'd4, RBW), "pop_s2_done");
    cyc1(mk(5'h14, 3'd4, ALE), "fetch_after_pop");

    // HALT, wake with ie=0 goes to FETCH
    bus1.ir = 4'hF;
    cyc1(mk(5'h15, 3'd4, IRW | PCW), "decode_halt");
    cyc1(mk(5'h0F, 3'd4, 8'h00), "halt_exec");
    cyc1(mk(5'h00, 3'd4, HLT), "halted0");
    cyc1(mk(5'h00, 3'd4, HLT), "halted1");
    cyc1(mk(5'h00, 3'd4, HLT), "halted2");
    bus1.irq = 1'b1;
    cyc1(mk(5'h00, 3'd4, HLT), "halted_irq");
    bus1.irq = 1'b0;
    cyc1(mk(5'h14, 3'd4, ALE), "fetch_after_wake");

    // Reset in the middle of a stalled PUSH
    bus1.ir = 4'h8;
    cyc1(mk(5'h15, 3'd4, IRW | PCW), "decode_push2");
    bus1.mem_rdy = 1'b0;
    cyc1(mk(5'h08, 3'd4, MEMW), "push2_wait");
    rst1 = 1'b1;
    cyc1(mk(5'h00, 3'd4, 8'h00), "rst_mid_push");
    rst1 = 1'b0;
    cyc1(mk(5'h10, 3'd4, ALE), "reboot_addr");
    cyc1(mk(5'h11, 3'd0, ALE), "reboot_k1_wait");

    // Second core: single boot register, memory ready ignored, wide opcodes
    cyc2(mk(5'h00, 3'd4, 8'h00), "c2_reset");
    rst2 = 1'b0;
    cyc2(mk(5'h10, 3'd4, ALE), "c2_boot_addr");
    cyc2(mk(5'h11, 3'd0, RBW), "c2_boot_k1");
    cyc2(mk(5'h14, 3'd4, ALE), "c2_fetch");
    bus2.ir = 6'h20;
    cyc2(mk(5'h15, 3'd4, IRW | PCW), "c2_decode_nowait");
    cyc2(mk(5'h00, 3'd4, 8'h00), "c2_wide_nop");
    cyc2(mk(5'h14, 3'd4, ALE), "c2_fetch2");
    bus2.ir = 6'h08;
    cyc2(mk(5'h15, 3'd4, IRW | PCW), "c2_decode_push");
    cyc2(mk(5'h08, 3'd4, MEMW | SPW), "c2_push_nowait");
    cyc2(mk(5'h14, 3'd4, ALE), "c2_fetch3");

    for (int i = 0; i < 5 && (q1.size() > 0 || q2.size() > 0); i++) @(posedge clk);
    if (q1.size() > 0 || q2.size() > 0) begin
      bad++;
      $display("FAIL drain: pending expectations q1=%0d q2=%0d required 0", q1.size(), q2.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
